// File: rtl/imem_boot_loader.sv
// Boot loader: assembles a length-prefixed little-endian byte stream into 32-bit
// words, writes them into instruction memory, then releases the core from reset.
module imem_boot_loader #(
  parameter int unsigned MAX_WORDS = 4096,
  parameter int unsigned IDX_W     = 13
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic [31:0] imem_waddress,
  output logic [31:0] imem_datain,
  output logic        imem_wr,
  output logic        cpu_reset,
  output logic        boot_done,
  output logic        boot_error
);

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    LOAD,
    WRITE,
    DONE,
    ERROR
  } bootState_t;

  bootState_t       state;
  bootState_t       nextState;
  logic [1:0]       byteCnt;
  logic [IDX_W-1:0] wordIdx;
  logic [31:0]      header;
  logic [31:0]      asmReg;

  logic             accept;
  logic [31:0]      headerNext;
  logic [31:0]      wordNext;
  logic [31:0]      idxPlusOne;
  logic [31:0]      addrNext;

  // Header is compared at full 32-bit width so huge counts cannot alias small ones.
  always_comb begin
    headerNext = {byte_data, header[31:8]};
    wordNext   = {byte_data, asmReg[31:8]};
    idxPlusOne = '0;
    idxPlusOne[IDX_W-1:0] = wordIdx;
    idxPlusOne = idxPlusOne + 32'd1;
    addrNext   = '0;
    addrNext[IDX_W+1:0] = {wordIdx, 2'b00};
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState  = state;
    byte_ready = 1'b0;
    imem_wr    = 1'b0;
    cpu_reset  = 1'b1;
    boot_done  = 1'b0;
    boot_error = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: nextState = LEN;
      LEN: begin
        byte_ready = 1'b1;
        accept     = byte_valid;
        if (accept && byteCnt == 2'd3) begin
          if (headerNext == 32'd0) begin
            nextState = DONE;
          end else if (headerNext > 32'(MAX_WORDS)) begin
            nextState = ERROR;
          end else begin
            nextState = LOAD;
          end
        end
      end
      LOAD: begin
        byte_ready = 1'b1;
        accept     = byte_valid;
        if (accept && byteCnt == 2'd3) begin
          nextState = WRITE;
        end
      end
      WRITE: begin
        imem_wr   = 1'b1;
        nextState = (idxPlusOne == header) ? DONE : LOAD;
      end
      DONE: begin
        cpu_reset = 1'b0;
        boot_done = 1'b1;
      end
      ERROR: begin
        boot_error = 1'b1;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      byteCnt       <= '0;
      wordIdx       <= '0;
      header        <= '0;
      asmReg        <= '0;
      imem_waddress <= '0;
      imem_datain   <= '0;
    end else begin
      case (state)
        LEN: begin
          if (accept) begin
            header  <= headerNext;
            byteCnt <= byteCnt + 2'd1;
          end
        end
        LOAD: begin
          if (accept) begin
            asmReg  <= wordNext;
            byteCnt <= byteCnt + 2'd1;
            // Address/data latched with the last byte so they hold steady through WRITE.
            if (byteCnt == 2'd3) begin
              imem_datain   <= wordNext;
              imem_waddress <= addrNext;
            end
          end
        end
        WRITE: begin
          byteCnt <= '0;
          if (nextState == LOAD) begin
            wordIdx <= wordIdx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: stream images, log memory writes, check outcomes.
module tb_imem_boot_loader;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic [31:0] imem_waddress;
  logic [31:0] imem_datain;
  logic        imem_wr;
  logic        cpu_reset;
  logic        boot_done;
  logic        boot_error;

  imem_boot_loader #(.MAX_WORDS(4096), .IDX_W(13)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .byte_ready(byte_ready),
    .imem_waddress(imem_waddress),
    .imem_datain(imem_datain),
    .imem_wr(imem_wr),
    .cpu_reset(cpu_reset),
    .boot_done(boot_done),
    .boot_error(boot_error)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad = 0;

  // Edge counter: 0 while in reset, N at the Nth edge after release.
  int cyc = 0;
  always @(posedge Clk) begin
    if (!Reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Write log and done-edge capture, sampled on the falling edge.
  logic [31:0] wAddr [64];
  logic [31:0] wData [64];
  int          nWr = 0;
  int          readyInWr = 0;
  int          doneEdge = -1;
  logic        prevCr = 1'b1;
  always @(negedge Clk) begin
    if (imem_wr) begin
      if (nWr < 64) begin
        wAddr[nWr] = imem_waddress;
        wData[nWr] = imem_datain;
      end
      nWr = nWr + 1;
      if (byte_ready) readyInWr = readyInWr + 1;
    end
    if (!Reset) doneEdge = -1;
    else if (prevCr && !cpu_reset) doneEdge = cyc;
    prevCr = cpu_reset;
  end

  logic [7:0] stream [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, ".byte_ready"}, {31'd0, byte_ready}, 32'd0);
    check({tag, ".imem_wr"},    {31'd0, imem_wr},    32'd0);
    check({tag, ".waddress"},   imem_waddress,       32'd0);
    check({tag, ".datain"},     imem_datain,         32'd0);
    check({tag, ".cpu_reset"},  {31'd0, cpu_reset},  32'd1);
    check({tag, ".boot_done"},  {31'd0, boot_done},  32'd0);
    check({tag, ".boot_error"}, {31'd0, boot_error}, 32'd0);
  endtask

  // Holds reset for two edges, checks reset outputs, releases just after an edge.
  task automatic doReset(input string tag);
    byte_valid = 1'b0;
    Reset = 1'b0;
    tick();
    tick();
    checkResetOutputs(tag);
    Reset = 1'b1;
  endtask

  task automatic sendStream(input int gap);
    int   waitCnt;
    logic taken;
    for (int i = 0; i < stream.size(); i++) begin
      byte_valid = 1'b1;
      byte_data  = stream[i];
      taken      = 1'b0;
      waitCnt    = 0;
      while (!taken && waitCnt < 50) begin
        taken = byte_ready;
        tick();
        waitCnt++;
      end
      check($sformatf("accept[%0d]", i), {31'd0, taken}, 32'd1);
      if (gap > 0) begin
        byte_valid = 1'b0;
        repeat (gap) tick();
      end
    end
    byte_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int acc;

    // Two-word load, byte_valid held high
    doReset("rst0");
    base = nWr;
    stream = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    sendStream(0);
    repeat (3) tick();
    check("two.nWr",    nWr - base,       32'd2);
    check("two.addr0",  wAddr[base],      32'h0000_0000);
    check("two.data0",  wData[base],      32'h0010_0513);
    check("two.addr1",  wAddr[base + 1],  32'h0000_0004);
    check("two.data1",  wData[base + 1],  32'h0020_0593);
    check("two.doneEdge", doneEdge,       32'd15);
    check("two.boot_done", {31'd0, boot_done}, 32'd1);
    check("two.cpu_reset", {31'd0, cpu_reset}, 32'd0);
    check("two.boot_error", {31'd0, boot_error}, 32'd0);

    // Terminal stickiness after DONE
    base = nWr;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      byte_valid = 1'b1;
      byte_data  = 8'h40 + 8'(i);
      if (byte_ready) acc++;
      tick();
    end
    byte_valid = 1'b0;
    check("sticky.accepts",   acc,        32'd0);
    check("sticky.nWr",       nWr - base, 32'd0);
    check("sticky.cpu_reset", {31'd0, cpu_reset}, 32'd0);
    check("sticky.boot_done", {31'd0, boot_done}, 32'd1);

    // Empty image
    doReset("rst1");
    base = nWr;
    stream = '{8'h00, 8'h00, 8'h00, 8'h00};
    sendStream(0);
    repeat (3) tick();
    check("empty.nWr",      nWr - base, 32'd0);
    check("empty.doneEdge", doneEdge,   32'd5);
    check("empty.byte_ready", {31'd0, byte_ready}, 32'd0);
    check("empty.boot_done",  {31'd0, boot_done},  32'd1);

    // Oversize header, N = 4097
    doReset("rst2");
    base = nWr;
    stream = '{8'h01, 8'h10, 8'h00, 8'h00};
    sendStream(0);
    repeat (3) tick();
    check("over.boot_error", {31'd0, boot_error}, 32'd1);
    check("over.boot_done",  {31'd0, boot_done},  32'd0);
    check("over.cpu_reset",  {31'd0, cpu_reset},  32'd1);
    check("over.byte_ready", {31'd0, byte_ready}, 32'd0);
    check("over.nWr",        nWr - base,          32'd0);

    // Oversize header with only the top bit set
    doReset("rst3");
    base = nWr;
    stream = '{8'h00, 8'h00, 8'h00, 8'h80};
    sendStream(0);
    repeat (3) tick();
    check("top.boot_error", {31'd0, boot_error}, 32'd1);
    check("top.cpu_reset",  {31'd0, cpu_reset},  32'd1);
    check("top.nWr",        nWr - base,          32'd0);

    // Exact maximum header is accepted (stream stops short; loader waits in LOAD)
    doReset("rst4");
    stream = '{8'h00, 8'h10, 8'h00, 8'h00};
    sendStream(0);
    repeat (3) tick();
    check("max.byte_ready", {31'd0, byte_ready}, 32'd1);
    check("max.boot_error", {31'd0, boot_error}, 32'd0);

    // Gapped two-word load
    doReset("rst5");
    base = nWr;
    stream = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    sendStream(3);
    repeat (3) tick();
    check("gap.nWr",   nWr - base,      32'd2);
    check("gap.addr0", wAddr[base],     32'h0000_0000);
    check("gap.data0", wData[base],     32'h0010_0513);
    check("gap.addr1", wAddr[base + 1], 32'h0000_0004);
    check("gap.data1", wData[base + 1], 32'h0020_0593);
    check("gap.boot_done", {31'd0, boot_done}, 32'd1);

    // Reset after the 6th payload byte
    doReset("rst6");
    base = nWr;
    stream = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    sendStream(0);
    check("mid.nWrBefore", nWr - base, 32'd1);
    check("mid.data0",     wData[base], 32'h4433_2211);
    Reset = 1'b0;
    tick();
    checkResetOutputs("mid.reset");
    tick();
    Reset = 1'b1;
    base = nWr;
    stream = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    sendStream(0);
    repeat (3) tick();
    check("fresh.nWr",   nWr - base,  32'd1);
    check("fresh.addr0", wAddr[base], 32'h0000_0000);
    check("fresh.data0", wData[base], 32'hDDCC_BBAA);
    check("fresh.doneEdge", doneEdge, 32'd10);
    check("fresh.boot_done", {31'd0, boot_done}, 32'd1);

    check("readyInWrite", readyInWr, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
